// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB-to-byte-memory controller.
//   state_t        : controller FSM states
//   lane_t         : byte lane index within a 32-bit word
//   BYTES_PER_WORD : byte lanes per APB word
//   APB_DATA_WIDTH : APB data bus width
package apb_mem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        TAIL,
        RESP,
        ERR
    } state_t;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/apb_mem_if.sv
// APB3 bus bundle between the interconnect (master) and apb_mem_ctrl (slave).
//   psel, penable, pwrite, paddr, pwdata, pstrb : master -> slave
//   prdata, pready, pslverr                     : slave -> master
interface apb_mem_if
    import apb_mem_pkg::*;
#(
    parameter int PADDR_WIDTH = 12
);
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [PADDR_WIDTH-1:0]        paddr;
    logic [APB_DATA_WIDTH-1:0]     pwdata;
    logic [BYTES_PER_WORD-1:0]     pstrb;
    logic [APB_DATA_WIDTH-1:0]     prdata;
    logic                          pready;
    logic                          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_ctrl.sv
// APB3 slave that maps 32-bit word accesses onto a byte-wide memory with a
// registered read port. Each word access is issued as four byte beats
// (lane 0 first); write strobes gate mem_cs per lane, read bytes are
// reassembled into prdata. Misaligned or out-of-range addresses get an
// immediate PSLVERR response without touching the memory.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   apb          : APB3 slave port (apb_mem_if.slave)
//   mem_cs       : memory chip select
//   mem_wr_rd_n  : 1 = write beat, 0 = read beat
//   mem_addr     : memory byte address
//   mem_data_in  : memory write data
//   mem_data_out : memory read data, valid the cycle after a read beat
module apb_mem_ctrl
    import apb_mem_pkg::*;
#(
    parameter int PADDR_WIDTH    = 12,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    apb_mem_if.slave                  apb,
    output logic                      mem_cs,
    output logic                      mem_wr_rd_n,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_in,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_out
);

    state_t                          state_reg, state_next;
    lane_t                           lane_reg, lane_next;
    lane_t                           lane_prev;
    logic [MEM_ADDR_WIDTH-3:0]       word_addr_reg;
    logic [APB_DATA_WIDTH-1:0]       pwdata_reg;
    logic [BYTES_PER_WORD-1:0]       pstrb_reg;
    logic [APB_DATA_WIDTH-1:0]       prdata_reg;
    logic                            setup;
    logic                            addr_err;

    assign setup    = apb.psel & ~apb.penable;
    assign addr_err = (apb.paddr[1:0] != 2'b00) ||
                      (apb.paddr[PADDR_WIDTH-1:MEM_ADDR_WIDTH] != '0);
    // Lane whose read byte arrives on mem_data_out this cycle.
    assign lane_prev = lane_reg - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            lane_reg  <= '0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        case (state_reg)
            IDLE: begin
                lane_next = '0;
                if (setup) begin
                    if (addr_err)        state_next = ERR;
                    else if (apb.pwrite) state_next = WR;
                    else                 state_next = RD;
                end
            end
            WR, RD: begin
                if (!apb.psel) begin
                    // Master abandoned the transfer: drop out without a response.
                    state_next = IDLE;
                    lane_next  = '0;
                end else if (lane_reg == 2'd3) begin
                    state_next = (state_reg == WR) ? RESP : TAIL;
                    lane_next  = '0;
                end else begin
                    lane_next = lane_reg + 2'd1;
                end
            end
            TAIL:    state_next = apb.psel ? RESP : IDLE;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory and response outputs depend only on registered state, so the
    // memory never sees a combinational path from the APB inputs.
    always_comb begin
        mem_cs      = 1'b0;
        mem_wr_rd_n = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        case (state_reg)
            WR: begin
                mem_wr_rd_n = 1'b1;
                mem_cs      = pstrb_reg[lane_reg];
                mem_addr    = {word_addr_reg, lane_reg};
                mem_data_in = pwdata_reg[{lane_reg, 3'b000} +: 8];
            end
            RD: begin
                mem_cs   = 1'b1;
                mem_addr = {word_addr_reg, lane_reg};
            end
            RESP: apb.pready = 1'b1;
            ERR: begin
                apb.pready  = 1'b1;
                apb.pslverr = 1'b1;
            end
            default: ;
        endcase
    end

    // Transfer direction is carried by the WR/RD state itself, so only the
    // word address, data and strobes need latching at setup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_addr_reg <= '0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
        end else if (state_reg == IDLE && setup) begin
            word_addr_reg <= apb.paddr[MEM_ADDR_WIDTH-1:2];
            pwdata_reg    <= apb.pwdata;
            pstrb_reg     <= apb.pstrb;
        end
    end

    // Read data lags the address by one cycle: lane k's beat collects lane
    // k-1's byte, and TAIL collects lane 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (setup && !addr_err && !apb.pwrite) prdata_reg <= '0;
                RD:   if (lane_reg != 2'd0) prdata_reg[{lane_prev, 3'b000} +: 8] <= mem_data_out;
                TAIL: prdata_reg[31:24] <= mem_data_out;
                default: ;
            endcase
        end
    end

    assign apb.prdata = prdata_reg;

endmodule

// File: tb/tb_apb_mem_ctrl.sv
module tb_apb_mem_ctrl;

    typedef struct {
        bit          is_read;
        bit          err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_cs;
    logic       mem_wr_rd_n;
    logic [9:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out = 8'h00;

    apb_mem_if #(.PADDR_WIDTH(12)) bus ();

    apb_mem_ctrl #(
        .PADDR_WIDTH(12),
        .MEM_ADDR_WIDTH(10),
        .MEM_DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .apb(bus),
        .mem_cs(mem_cs),
        .mem_wr_rd_n(mem_wr_rd_n),
        .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit err_window = 1'b0;

    exp_t  exp_q[$];
    beat_t beat_q[$];

    logic [7:0] mem_arr [1024];   // the memory instance behind the controller
    logic [7:0] ref_mem [1024];   // what the bench believes the memory holds

    always @(posedge clk) cyc++;

    // Byte memory with registered read.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wr_rd_n) mem_arr[mem_addr] <= mem_data_in;
            else             mem_data_out <= mem_arr[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: responses and write beats are compared against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pslverr", {31'd0, bus.pslverr}, {31'd0, e.err});
                    chk("latency", cyc, e.cyc);
                    if (e.is_read && !e.err) chk("prdata", bus.prdata, e.data);
                    $display("resp %s err=%0d prdata=%h cyc=%0d", e.is_read ? "RD" : "WR",
                             bus.pslverr, bus.prdata, cyc);
                end
            end
            if (mem_cs && mem_wr_rd_n) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_write_beat", {22'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_addr", {22'd0, mem_addr}, {22'd0, b.addr});
                    chk("beat_data", {24'd0, mem_data_in}, {24'd0, b.data});
                end
            end
            if (err_window) chk("mem_cs_in_err", {31'd0, mem_cs}, 32'd0);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_prdata"}, bus.prdata, 32'd0);
        chk({tag, "_pready"}, {31'd0, bus.pready}, 32'd0);
        chk({tag, "_pslverr"}, {31'd0, bus.pslverr}, 32'd0);
        chk({tag, "_mem_cs"}, {31'd0, mem_cs}, 32'd0);
        chk({tag, "_mem_wr_rd_n"}, {31'd0, mem_wr_rd_n}, 32'd0);
        chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_data_in"}, {24'd0, mem_data_in}, 32'd0);
    endtask

    // One APB transfer; expectations come from the word-level reference model.
    task automatic apb_xfer(input bit write, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        bit   err;
        int   n;
        logic [9:0] base;
        err  = (addr[1:0] != 2'b00) || (addr >= 12'h400);
        base = addr[9:0];
        e.is_read = !write;
        e.err     = err;
        e.data    = 32'd0;
        if (err) e.cyc = cyc + 1;
        else     e.cyc = cyc + (write ? 5 : 6);
        if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (write) begin
                    if (strb[i]) begin
                        beat_t b;
                        b.addr = base + 10'(i);
                        b.data = data[8*i +: 8];
                        beat_q.push_back(b);
                        ref_mem[base + 10'(i)] = data[8*i +: 8];
                    end
                end else begin
                    e.data[8*i +: 8] = ref_mem[base + 10'(i)];
                end
            end
        end
        exp_q.push_back(e);
        err_window  = err;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = write;
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.pstrb   = strb;
        @(posedge clk) #1;
        bus.penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pready && n < 20);
        if (!bus.pready) chk("pready_timeout", 32'd0, 32'd1);
        @(posedge clk) #1;
        err_window = 1'b0;
    endtask

    task automatic go_idle(input int cycles);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;    bus.pstrb = '0;

        #2;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk) #1;

        // Full write and read-back.
        apb_xfer(1'b1, 12'h010, 32'h1234_5678, 4'b1111);
        go_idle(1);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'b0000);
        go_idle(1);
        // Partial strobes: lanes 0 and 2 only.
        apb_xfer(1'b1, 12'h010, 32'hAABB_CCDD, 4'b0101);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'b1111);
        // Zero strobe write still completes.
        apb_xfer(1'b1, 12'h010, 32'hFFFF_FFFF, 4'b0000);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'b0000);
        go_idle(2);
        // Misaligned and out-of-range addresses.
        apb_xfer(1'b1, 12'h402, 32'hDEAD_BEEF, 4'b1111);
        apb_xfer(1'b0, 12'h400, 32'h0, 4'b0000);
        apb_xfer(1'b0, 12'h013, 32'h0, 4'b0000);
        // Back-to-back at the top word.
        apb_xfer(1'b1, 12'h3FC, 32'hCAFE_F00D, 4'b1111);
        apb_xfer(1'b0, 12'h3FC, 32'h0, 4'b0000);
        go_idle(1);

        // Reset during the lane-2 write beat: lanes 0-1 land, 2-3 keep old data.
        apb_xfer(1'b1, 12'h020, 32'h1122_3344, 4'b1111);
        go_idle(1);
        begin
            beat_t b;
            b.addr = 10'h020; b.data = 8'hA8; beat_q.push_back(b);
            b.addr = 10'h021; b.data = 8'hA7; beat_q.push_back(b);
            ref_mem[10'h020] = 8'hA8;
            ref_mem[10'h021] = 8'hA7;
        end
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h020; bus.pwdata = 32'hA5A6_A7A8; bus.pstrb = 4'b1111;
        @(posedge clk) #1;
        bus.penable = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk) #1;
        apb_xfer(1'b0, 12'h020, 32'h0, 4'b0000);
        go_idle(1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic [11:0] a;
            if ($urandom_range(0, 9) < 8) a = {2'b00, 8'($urandom_range(0, 255)), 2'b00};
            else                          a = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) a = {2'b00, 8'($urandom_range(0, 3)), 2'b00};
            apb_xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
        end
        go_idle(4);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("beat_q_drained", beat_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_mem_ctrl.md
Name: apb_mem_ctrl

Overview:
APB3 slave controller that sequences the 1024x8 byte memory (cs / wr_rd_n / addr / data_in / data_out, registered read) as a 32-bit word-addressed peripheral. Each APB word access is split into four byte beats on the memory port, with write strobes honoured and read bytes reassembled. The block inserts APB wait states until the beats complete and flags bad addresses with PSLVERR. It sits between the APB interconnect and the memory instance.

Parameters:
PADDR_WIDTH, 12, APB byte-address width
MEM_ADDR_WIDTH, 10, memory address width (memory depth = 2**MEM_ADDR_WIDTH bytes)
MEM_DATA_WIDTH, 8, memory data width (fixed; 4 lanes per 32-bit word)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1 = write, 0 = read
paddr  in  PADDR_WIDTH  APB byte address
pwdata  in  32  write data
pstrb  in  4  byte strobes; bit i = lane i = pwdata[8i+7:8i]
prdata  out  32  read data
pready  out  1  transfer complete
pslverr  out  1  error response
mem_cs  out  1  memory chip select
mem_wr_rd_n  out  1  1 = write, 0 = read
mem_addr  out  MEM_ADDR_WIDTH  memory byte address
mem_data_in  out  8  memory write data
mem_data_out  in  8  memory read data; valid one cycle after the address is presented with wr_rd_n = 0

Behaviour:
- Reset (async, rst = 1): state IDLE, lane = 0; prdata = 0, pready = 0, pslverr = 0, mem_cs = 0, mem_wr_rd_n = 0, mem_addr = 0, mem_data_in = 0.
- Setup detect: in IDLE, psel & ~penable latches paddr, pwdata, pstrb and pwrite into registers.
- Error check at setup: an error is flagged if paddr[1:0] != 0 or paddr[PADDR_WIDTH-1:MEM_ADDR_WIDTH] != 0.
- States and transitions:
  - IDLE -> ERR on error; -> WR on pwrite; -> RD otherwise.
  - WR, lanes 0..3, one cycle each: mem_wr_rd_n = 1, mem_cs = pstrb_q[lane], mem_addr = {paddr_q[MEM_ADDR_WIDTH-1:2], lane}, mem_data_in = pwdata_q lane byte. Lane 3 -> RESP.
  - RD, lanes 0..3, one cycle each: mem_cs = 1, mem_wr_rd_n = 0, addr as for WR. prdata is cleared on RD entry. The byte for lane k-1 is captured into prdata from mem_data_out at the end of the lane-k cycle. Lane 3 -> TAIL.
  - TAIL: mem_cs = 0; captures the lane-3 byte -> RESP.
  - RESP: pready = 1 (pslverr = 0) -> IDLE.
  - ERR: pready = 1, pslverr = 1, no memory access -> IDLE.
- Latency from setup cycle S to pready cycle:
  - write: 4 beats, pready in cycle S+5
  - read: pready in cycle S+6
  - error: pready in cycle S+1 (zero wait states)
- Outputs are decoded only from state, lane and latched registers; no combinational path from APB inputs to mem_* or pready.
- mem_wr_rd_n is 0 whenever the block is not in WR, so the memory never writes outside a WR beat.
- Strobes:
  - pstrb = 0000 write: still takes 4 beats with no mem_cs, then an OKAY response.
  - Reads ignore pstrb.
- prdata holds its last value outside RESP; it is only meaningful when pready & ~pwrite_q.
- psel deasserted in WR/RD/TAIL (protocol violation): abort to IDLE next cycle, mem_cs = 0. Bytes already written stay written; no response is given.
- psel & ~penable seen outside IDLE is ignored.
- Back-to-back transfers: a setup cycle directly following RESP/ERR is accepted, since the state is IDLE in that cycle.
- Reset asserted mid-operation: immediate return to reset values. A partial write is not rolled back.

Decomposition:
- Package apb_mem_pkg:
  - state enum {IDLE, WR, RD, TAIL, RESP, ERR}
  - lane_t (2-bit)
  - BYTES_PER_WORD = 4
  - APB_DATA_WIDTH = 32
- Single module: FSM, lane counter and prdata assembly together are under 300 lines. No sub-module.

Test Plan:
- Write 0x12345678, pstrb 1111, paddr 0x010 -> mem writes addr 0x010..0x013 = 78,56,34,12 on consecutive cycles; pready in cycle S+5, pslverr = 0.
- Read back paddr 0x010 -> mem reads addr 0x010..0x013; prdata = 0x12345678 with pready in cycle S+6.
- Write 0xAABBCCDD, pstrb 0101, paddr 0x010, then read -> prdata = 0x12BB56DD; mem_cs high only on lanes 0 and 2.
- paddr 0x402 (misaligned) and paddr 0x400 (out of range) -> pready & pslverr in cycle S+1; mem_cs never asserted.
- Back-to-back write then read to paddr 0x3FC -> second setup accepted in the cycle after RESP; read returns the written word; address wraps correctly at the top word.
- rst pulsed during the WR lane-2 beat -> all outputs 0 immediately; the next transfer completes normally; memory lanes 0-1 hold new data and lanes 2-3 hold old data.
